// File: rtl/md_ctrl_if.sv
// md_ctrl_if: EX-stage md op, mul/div unit handshakes and HI/LO between md_ctrl and its neighbours
interface md_ctrl_if;
  logic        ex_stall;
  logic        flush;
  logic        op_valid;
  logic [2:0]  op_type;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        mul_signed;
  logic [31:0] mul_ina;
  logic [31:0] mul_inb;
  logic [63:0] mul_result;
  logic        div_start;
  logic        div_annul;
  logic        div_signed;
  logic [31:0] div_opa;
  logic [31:0] div_opb;
  logic        div_ready;
  logic [63:0] div_result;
  logic        stallreq;
  logic [31:0] hi;
  logic [31:0] lo;
  modport slave (
    input  ex_stall, flush, op_valid, op_type, src_a, src_b, mul_result, div_ready, div_result,
    output mul_signed, mul_ina, mul_inb, div_start, div_annul, div_signed, div_opa, div_opb,
           stallreq, hi, lo
  );
  modport master (
    output ex_stall, flush, op_valid, op_type, src_a, src_b, mul_result, div_ready, div_result,
    input  mul_signed, mul_ina, mul_inb, div_start, div_annul, div_signed, div_opa, div_opb,
           stallreq, hi, lo
  );
endinterface

// File: rtl/md_ctrl.sv
// md_ctrl: sequences mul/div units and owns HI/LO; MD_DIVZERO_FAST_EN short-circuits divide-by-zero
module md_ctrl #(
  parameter int MUL_LAT = 2
) (
  input logic       clk,
  input logic       rst,
  md_ctrl_if.slave  md
);
  localparam int CW = MUL_LAT > 1 ? $clog2(MUL_LAT) : 1;
  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   hi_q, lo_q, mul_a_q, mul_b_q, div_a_q, div_b_q;
  logic          mul_signed_q, div_signed_q;
  logic          is_mul, is_div;
  assign is_mul = md.op_valid & ((md.op_type == 3'd0) | (md.op_type == 3'd1));
  assign is_div = md.op_valid & ((md.op_type == 3'd2) | (md.op_type == 3'd3));
  assign md.stallreq   = ((state_q == IDLE) & (is_mul | is_div) & ~md.flush)
                       | (state_q == MUL_WAIT) | (state_q == DIV_WAIT);
  assign md.div_start  = (state_q == DIV_WAIT) & ~md.flush & ~md.div_ready;
  assign md.div_annul  = (state_q == DIV_WAIT) & md.flush;
  assign md.div_signed = div_signed_q;
  assign md.div_opa    = div_a_q;
  assign md.div_opb    = div_b_q;
  assign md.mul_signed = mul_signed_q;
  assign md.mul_ina    = mul_a_q;
  assign md.mul_inb    = mul_b_q;
  assign md.hi         = hi_q;
  assign md.lo         = lo_q;
  // flush outranks any completion landing in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      div_a_q      <= '0;
      div_b_q      <= '0;
      mul_signed_q <= 1'b0;
      div_signed_q <= 1'b0;
    end else if (md.flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (is_mul) begin
            mul_a_q      <= md.src_a;
            mul_b_q      <= md.src_b;
            mul_signed_q <= ~md.op_type[0];
            cnt_q        <= CW'(MUL_LAT - 1);
            state_q      <= MUL_WAIT;
          end else if (is_div) begin
            div_a_q      <= md.src_a;
            div_b_q      <= md.src_b;
            div_signed_q <= ~md.op_type[0];
`ifdef MD_DIVZERO_FAST_EN
            if (md.src_b == '0) begin
              hi_q    <= md.src_a;
              lo_q    <= '1;
              state_q <= DONE;
            end else state_q <= DIV_WAIT;
`else
            state_q      <= DIV_WAIT;
`endif
          end else if (md.op_valid & ~md.ex_stall) begin
            if (md.op_type == 3'd4) hi_q <= md.src_a;
            if (md.op_type == 3'd5) lo_q <= md.src_a;
          end
        end
        MUL_WAIT: begin
          if (cnt_q == '0) begin
            {hi_q, lo_q} <= md.mul_result;
            state_q      <= DONE;
          end else cnt_q <= cnt_q - 1'b1;
        end
        DIV_WAIT: begin
          if (md.div_ready) begin
            {hi_q, lo_q} <= md.div_result;
            state_q      <= DONE;
          end
        end
        default: if (~md.ex_stall) state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: table of md ops against behavioural mul/div units, plus flush/reset sequences
module tb_md_ctrl;
  localparam int DIV_LAT = 33;
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          hold;
    logic [31:0] hi;
    logic [31:0] lo;
    int          stall;
    int          starts;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hold = 1'b0;
  logic ds_prev;
  logic [63:0] mul_q;
  int dcnt;
  int starts = 0;
  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];
  vec_t tab[10];
  md_ctrl_if bus();
  md_ctrl #(.MUL_LAT(2)) dut (.clk(clk), .rst(rst), .md(bus.slave));
  always #5 clk = ~clk;
  assign bus.ex_stall = bus.stallreq | hold;
  always_ff @(posedge clk) begin
    if (bus.mul_signed) mul_q <= $signed({{32{bus.mul_ina[31]}}, bus.mul_ina}) * $signed({{32{bus.mul_inb[31]}}, bus.mul_inb});
    else mul_q <= {32'b0, bus.mul_ina} * {32'b0, bus.mul_inb};
  end
  assign bus.mul_result = mul_q;
  function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction
  always_ff @(posedge clk) begin
    dcnt    <= (rst | ~bus.div_start) ? 0 : dcnt + 1;
    ds_prev <= rst ? 1'b0 : bus.div_start;
    if (!rst && bus.div_start && !ds_prev) starts <= starts + 1;
  end
  assign bus.div_ready  = (dcnt == DIV_LAT - 1);
  assign bus.div_result = div_model(bus.div_opa, bus.div_opb, bus.div_signed);
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic run_op(input int idx, input vec_t v);
    int n, s0;
    logic ok;
    logic [63:0] e;
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_type  = v.op;
    bus.src_a    = v.a;
    bus.src_b    = v.b;
    sb.push_back({v.hi, v.lo});
    s0 = starts;
    n  = 0;
    #1;
    while (bus.stallreq && n < 200) begin
      n++;
      @(negedge clk);
      bus.src_a = $urandom;
      bus.src_b = $urandom;
      #1;
    end
    ok   = 1'b1;
    hold = (v.hold != 0);
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      #1;
      if (bus.stallreq || bus.div_start) ok = 1'b0;
    end
    hold = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    chk($sformatf("row%0d stall", idx), 64'(n), 64'(v.stall));
    chk($sformatf("row%0d hi", idx), {32'b0, bus.hi}, {32'b0, e[63:32]});
    chk($sformatf("row%0d lo", idx), {32'b0, bus.lo}, {32'b0, e[31:0]});
    chk($sformatf("row%0d div_start bursts", idx), 64'(starts - s0), 64'(v.starts));
    if (v.hold != 0) chk($sformatf("row%0d quiet in DONE", idx), {63'b0, ok}, 64'd1);
    bus.op_valid = 1'b0;
  endtask
  initial begin
    tab[0] = '{3'd0, 32'hFFFF_FFFD, 32'd7, 2, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 3, 0};
    tab[1] = '{3'd1, 32'hFFFF_FFFF, 32'd2, 0, 32'h0000_0001, 32'hFFFF_FFFE, 3, 0};
    tab[2] = '{3'd3, 32'd100, 32'd7, 0, 32'd2, 32'd14, DIV_LAT + 1, 1};
    tab[3] = '{3'd2, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT + 1, 1};
    tab[4] = '{3'd4, 32'hDEAD_BEEF, 32'd0, 0, 32'hDEAD_BEEF, 32'hFFFF_FFFD, 0, 0};
    tab[5] = '{3'd5, 32'h1234_5678, 32'd0, 0, 32'hDEAD_BEEF, 32'h1234_5678, 0, 0};
    tab[6] = '{3'd2, 32'd100, 32'hFFFF_FFF9, 4, 32'd2, 32'hFFFF_FFF2, DIV_LAT + 1, 1};
    tab[7] = '{3'd3, 32'hFFFF_FFFF, 32'd16, 0, 32'h0000_000F, 32'h0FFF_FFFF, DIV_LAT + 1, 1};
`ifdef MD_DIVZERO_FAST_EN
    tab[8] = '{3'd2, 32'd5, 32'd0, 0, 32'd5, 32'hFFFF_FFFF, 1, 0};
`else
    tab[8] = '{3'd2, 32'd5, 32'd0, 0, 32'd5, 32'hFFFF_FFFF, DIV_LAT + 1, 1};
`endif
    tab[9] = '{3'd6, 32'd1, 32'd1, 0, 32'd5, 32'hFFFF_FFFF, 0, 0};
    bus.flush = 1'b0;
    bus.op_valid = 1'b0;
    bus.op_type = 3'd0;
    bus.src_a = 32'd0;
    bus.src_b = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset hi", {32'b0, bus.hi}, 64'd0);
    chk("reset lo", {32'b0, bus.lo}, 64'd0);
    chk("reset stallreq", {63'b0, bus.stallreq}, 64'd0);
    chk("reset div_start", {63'b0, bus.div_start}, 64'd0);
    chk("reset div_annul", {63'b0, bus.div_annul}, 64'd0);
    chk("reset signs", {62'b0, bus.mul_signed, bus.div_signed}, 64'd0);
    chk("reset operands", {bus.mul_ina, bus.div_opb}, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) run_op(i, tab[i]);
    // flush a divide mid-flight
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_type  = 3'd2;
    bus.src_a    = 32'd100;
    bus.src_b    = 32'd7;
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    #1;
    chk("flush div_annul", {63'b0, bus.div_annul}, 64'd1);
    chk("flush div_start", {63'b0, bus.div_start}, 64'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    bus.op_valid = 1'b0;
    #1;
    chk("post-flush idle", {62'b0, bus.stallreq, bus.div_start}, 64'd0);
    chk("post-flush hi/lo", {bus.hi, bus.lo}, {32'd5, 32'hFFFF_FFFF});
    run_op(10, '{3'd0, 32'd2, 32'd3, 0, 32'd0, 32'd6, 3, 0});
    // flush lands on the mul completion cycle
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_type  = 3'd0;
    bus.src_a    = 32'd4;
    bus.src_b    = 32'd5;
    repeat (2) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.op_valid = 1'b0;
    #1;
    chk("mul flush hi/lo", {bus.hi, bus.lo}, {32'd0, 32'd6});
    chk("mul flush stallreq", {63'b0, bus.stallreq}, 64'd0);
    // reset while a divide is running
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_type  = 3'd3;
    bus.src_a    = 32'd9;
    bus.src_b    = 32'd3;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    bus.op_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("mid-op reset hi/lo", {bus.hi, bus.lo}, 64'd0);
    chk("mid-op reset handshake", {62'b0, bus.div_start, bus.stallreq}, 64'd0);
    rst = 1'b0;
    chk("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
